secuenciador_partida: RTL and testbench

Match sequencer for the tic-tac-toe game: runs a best-of-N match of rounds on top of the existing game datapath (cell selector, board register, line verifier). Clears the board at each round start, grants turns, alternates the opening player between rounds, enforces a per-turn timeout, requests a board check after every committed move, and keeps the match score. Sits between the board/selector/verifier datapath and the display/LED logic.

---
 rtl/gato_pkg.sv | 25 ++
 rtl/temporizador_turno.sv | 29 ++
 rtl/secuenciador_partida.sv | 162 ++++++++++++++++
 tb/tb_secuenciador_partida.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/gato_pkg.sv
// Shared types and constants for the tic-tac-toe match sequencer.
package gato_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_TURN,
    S_CHECK,
    S_ROUND_END,
    S_MATCH_END
  } state_t;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_TIE  = 2'b11;

  localparam logic PLAYER_P1 = 1'b0;
  localparam logic PLAYER_P2 = 1'b1;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/temporizador_turno.sv
// Per-turn timer: counts cycles while enabled, pulses o_tc on the last cycle of a turn.
module temporizador_turno #(
  parameter int unsigned TURN_TICKS = 100_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  localparam int unsigned W = $clog2(TURN_TICKS);
  localparam logic [W-1:0] LP_LAST = W'(TURN_TICKS - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_tc = i_enable && (r_cnt == LP_LAST);

endmodule

// File: rtl/secuenciador_partida.sv
// Best-of-N tic-tac-toe match sequencer: turns, board check requests, score keeping.
// Optional per-turn timeout enabled with macro TURN_TIMEOUT_EN.
//   state       | meaning
//   S_IDLE      | after reset, waiting for start
//   S_CLEAR     | board clear pulse, load opening player
//   S_TURN      | grant to current player, waiting for its move
//   S_CHECK     | board check requested, waiting for verifier result
//   S_ROUND_END | round decided, waiting for start
//   S_MATCH_END | match decided, waiting for start
module secuenciador_partida
  import gato_pkg::*;
#(
  parameter int unsigned TURN_TICKS    = 100_000_000,
  parameter int unsigned WINS_TO_MATCH = 3
) (
  input  logic       i_clk,
  input  logic       i_reset_all_n,
  input  logic       i_start,
  input  logic       i_move_done,
  input  logic       i_move_player,
  input  logic       i_result_valid,
  input  logic [1:0] i_result,
  output logic       o_clear_board,
  output logic       o_turno_p1,
  output logic       o_turno_p2,
  output logic       o_verifica,
  output logic       o_timeout_flag,
  output logic       o_round_over,
  output logic       o_match_over,
  output logic [1:0] o_winner,
  output logic [3:0] o_score_p1,
  output logic [3:0] o_score_p2
);

  localparam logic [3:0] LP_WINS = 4'(WINS_TO_MATCH);

  state_t     r_state;
  logic       r_player;
  logic       r_first;
  logic       r_verifica;
  logic       r_timeout;
  logic [1:0] r_winner;
  logic [3:0] r_score_p1;
  logic [3:0] r_score_p2;

  logic       w_tc;
  logic       w_move_ok;
  logic [3:0] w_p1_next;
  logic [3:0] w_p2_next;

`ifdef TURN_TIMEOUT_EN
  logic w_timer_clear;
  logic w_timer_en;

  assign w_timer_en    = (r_state == S_TURN);
  assign w_timer_clear = !w_timer_en || w_tc;

  temporizador_turno #(
    .TURN_TICKS(TURN_TICKS)
  ) u_temporizador (
    .i_clk    (i_clk),
    .i_rst_n  (i_reset_all_n),
    .i_clear  (w_timer_clear),
    .i_enable (w_timer_en),
    .o_tc     (w_tc)
  );
`else
  // Never true for a legal TURN_TICKS: a turn lasts until a valid move.
  assign w_tc = (TURN_TICKS == 0);
`endif

  assign w_move_ok = i_move_done && (i_move_player == r_player);
  assign w_p1_next = sat_inc(r_score_p1);
  assign w_p2_next = sat_inc(r_score_p2);

  always_ff @(posedge i_clk or negedge i_reset_all_n) begin
    if (!i_reset_all_n) begin
      r_state    <= S_IDLE;
      r_player   <= PLAYER_P1;
      r_first    <= PLAYER_P1;
      r_verifica <= 1'b0;
      r_timeout  <= 1'b0;
      r_winner   <= RES_NONE;
      r_score_p1 <= 4'd0;
      r_score_p2 <= 4'd0;
    end else begin
      r_verifica <= 1'b0;
      r_timeout  <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) r_state <= S_CLEAR;
        S_CLEAR: begin
          r_player <= r_first;
          r_state  <= S_TURN;
        end
        S_TURN: begin
          // A move landing on the expiry cycle takes precedence over the timeout.
          if (w_move_ok) begin
            r_state    <= S_CHECK;
            r_verifica <= 1'b1;
          end else if (w_tc) begin
            r_player  <= ~r_player;
            r_timeout <= 1'b1;
          end
        end
        S_CHECK: if (i_result_valid) begin
          case (i_result)
            RES_NONE: begin
              r_player <= ~r_player;
              r_state  <= S_TURN;
            end
            RES_P1: begin
              r_score_p1 <= w_p1_next;
              r_winner   <= RES_P1;
              if (w_p1_next == LP_WINS) begin
                r_state <= S_MATCH_END;
              end else begin
                r_state <= S_ROUND_END;
                r_first <= ~r_first;
              end
            end
            RES_P2: begin
              r_score_p2 <= w_p2_next;
              r_winner   <= RES_P2;
              if (w_p2_next == LP_WINS) begin
                r_state <= S_MATCH_END;
              end else begin
                r_state <= S_ROUND_END;
                r_first <= ~r_first;
              end
            end
            default: begin
              r_winner <= RES_TIE;
              r_state  <= S_ROUND_END;
              r_first  <= ~r_first;
            end
          endcase
        end
        S_ROUND_END: if (i_start) r_state <= S_CLEAR;
        S_MATCH_END: if (i_start) begin
          r_score_p1 <= 4'd0;
          r_score_p2 <= 4'd0;
          r_winner   <= RES_NONE;
          r_first    <= PLAYER_P1;
          r_state    <= S_CLEAR;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_clear_board  = (r_state == S_CLEAR);
  assign o_turno_p1     = (r_state == S_TURN) && (r_player == PLAYER_P1);
  assign o_turno_p2     = (r_state == S_TURN) && (r_player == PLAYER_P2);
  assign o_verifica     = r_verifica;
  assign o_timeout_flag = r_timeout;
  assign o_round_over   = (r_state == S_ROUND_END);
  assign o_match_over   = (r_state == S_MATCH_END);
  assign o_winner       = r_winner;
  assign o_score_p1     = r_score_p1;
  assign o_score_p2     = r_score_p2;

endmodule

// File: tb/tb_secuenciador_partida.sv
// Directed self-checking bench for secuenciador_partida (TURN_TICKS=8, WINS_TO_MATCH=2).
module tb_secuenciador_partida;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       move_done = 1'b0;
  logic       move_player = 1'b0;
  logic       result_valid = 1'b0;
  logic [1:0] result = 2'b00;

  logic       clear_board, turno_p1, turno_p2, verifica, timeout_flag;
  logic       round_over, match_over;
  logic [1:0] winner;
  logic [3:0] score_p1, score_p2;
  logic [16:0] obs;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  secuenciador_partida #(
    .TURN_TICKS(8),
    .WINS_TO_MATCH(2)
  ) dut (
    .i_clk          (clk),
    .i_reset_all_n  (rst_n),
    .i_start        (start),
    .i_move_done    (move_done),
    .i_move_player  (move_player),
    .i_result_valid (result_valid),
    .i_result       (result),
    .o_clear_board  (clear_board),
    .o_turno_p1     (turno_p1),
    .o_turno_p2     (turno_p2),
    .o_verifica     (verifica),
    .o_timeout_flag (timeout_flag),
    .o_round_over   (round_over),
    .o_match_over   (match_over),
    .o_winner       (winner),
    .o_score_p1     (score_p1),
    .o_score_p2     (score_p2)
  );

  assign obs = {clear_board, turno_p1, turno_p2, verifica, timeout_flag,
                round_over, match_over, winner, score_p1, score_p2};

  function automatic logic [16:0] ev(input logic clr, input logic p1, input logic p2,
                                     input logic ver, input logic to, input logic ro,
                                     input logic mo, input logic [1:0] w,
                                     input logic [3:0] s1, input logic [3:0] s2);
    return {clr, p1, p2, ver, to, ro, mo, w, s1, s2};
  endfunction

  task automatic chk(input string tag, input logic [16:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic move(input logic p);
    move_done = 1'b1;
    move_player = p;
    tick();
    move_done = 1'b0;
  endtask

  task automatic res(input logic [1:0] r);
    result_valid = 1'b1;
    result = r;
    tick();
    result_valid = 1'b0;
    result = 2'b00;
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_state", ev(0,0,0,0,0,0,0,2'b00,4'd0,4'd0));
    rst_n = 1'b1;
    tick();
    chk("idle", ev(0,0,0,0,0,0,0,2'b00,4'd0,4'd0));

    pulse_start();
    chk("clear_pulse", ev(1,0,0,0,0,0,0,2'b00,4'd0,4'd0));
    tick();
    chk("grant_p1", ev(0,1,0,0,0,0,0,2'b00,4'd0,4'd0));
    tick();
    chk("grant_p1_hold", ev(0,1,0,0,0,0,0,2'b00,4'd0,4'd0));

    pulse_start();
    chk("start_ign_turn", ev(0,1,0,0,0,0,0,2'b00,4'd0,4'd0));
    res(2'b01);
    chk("result_ign_turn", ev(0,1,0,0,0,0,0,2'b00,4'd0,4'd0));
    move(1'b1);
    chk("wrong_player_p1", ev(0,1,0,0,0,0,0,2'b00,4'd0,4'd0));

    move(1'b0);
    chk("verifica_p1", ev(0,0,0,1,0,0,0,2'b00,4'd0,4'd0));
    tick();
    chk("check_wait", ev(0,0,0,0,0,0,0,2'b00,4'd0,4'd0));
    res(2'b00);
    chk("turn_to_p2", ev(0,0,1,0,0,0,0,2'b00,4'd0,4'd0));
    move(1'b0);
    chk("wrong_player_p2", ev(0,0,1,0,0,0,0,2'b00,4'd0,4'd0));

    move(1'b1);
    chk("verifica_p2", ev(0,0,0,1,0,0,0,2'b00,4'd0,4'd0));
    res(2'b00);
    chk("result_on_ver_cycle", ev(0,1,0,0,0,0,0,2'b00,4'd0,4'd0));

    move(1'b0);
    res(2'b01);
    chk("p1_wins_round", ev(0,0,0,0,0,1,0,2'b01,4'd1,4'd0));
    move(1'b0);
    chk("move_ign_round_end", ev(0,0,0,0,0,1,0,2'b01,4'd1,4'd0));
    pulse_start();
    chk("clear_round2", ev(1,0,0,0,0,0,0,2'b01,4'd1,4'd0));
    tick();
    chk("p2_opens_round2", ev(0,0,1,0,0,0,0,2'b01,4'd1,4'd0));

    move(1'b1);
    res(2'b10);
    chk("p2_wins_round", ev(0,0,0,0,0,1,0,2'b10,4'd1,4'd1));
    pulse_start();
    tick();
    chk("p1_opens_round3", ev(0,1,0,0,0,0,0,2'b10,4'd1,4'd1));

    move(1'b0);
    res(2'b11);
    chk("tie_round", ev(0,0,0,0,0,1,0,2'b11,4'd1,4'd1));
    pulse_start();
    tick();
    chk("p2_opens_round4", ev(0,0,1,0,0,0,0,2'b11,4'd1,4'd1));

    move(1'b1);
    res(2'b10);
    chk("match_over", ev(0,0,0,0,0,0,1,2'b10,4'd1,4'd2));
    tick();
    chk("match_hold", ev(0,0,0,0,0,0,1,2'b10,4'd1,4'd2));
    pulse_start();
    chk("match_restart_clear", ev(1,0,0,0,0,0,0,2'b00,4'd0,4'd0));
    tick();
    chk("p1_opens_match2", ev(0,1,0,0,0,0,0,2'b00,4'd0,4'd0));

    move(1'b0);
    chk("verifica_before_reset", ev(0,0,0,1,0,0,0,2'b00,4'd0,4'd0));
    #2 rst_n = 1'b0;
    #1 chk("async_reset", ev(0,0,0,0,0,0,0,2'b00,4'd0,4'd0));
    tick();
    chk("reset_hold", ev(0,0,0,0,0,0,0,2'b00,4'd0,4'd0));
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_after_reset", ev(0,0,0,0,0,0,0,2'b00,4'd0,4'd0));
    pulse_start();
    tick();
    chk("p1_after_reset", ev(0,1,0,0,0,0,0,2'b00,4'd0,4'd0));

`ifdef TURN_TIMEOUT_EN
    repeat (7) tick();
    chk("to_hold_p1", ev(0,1,0,0,0,0,0,2'b00,4'd0,4'd0));
    tick();
    chk("timeout_1", ev(0,0,1,0,1,0,0,2'b00,4'd0,4'd0));
    tick();
    chk("timeout_pulse_1cyc", ev(0,0,1,0,0,0,0,2'b00,4'd0,4'd0));
    repeat (6) tick();
    chk("to_hold_p2", ev(0,0,1,0,0,0,0,2'b00,4'd0,4'd0));
    tick();
    chk("timeout_2", ev(0,1,0,0,1,0,0,2'b00,4'd0,4'd0));
    repeat (7) tick();
    chk("to_hold_p1_again", ev(0,1,0,0,0,0,0,2'b00,4'd0,4'd0));
    move(1'b0);
    chk("move_beats_timeout", ev(0,0,0,1,0,0,0,2'b00,4'd0,4'd0));
`else
    repeat (20) tick();
    chk("no_timeout", ev(0,1,0,0,0,0,0,2'b00,4'd0,4'd0));
    move(1'b0);
    chk("late_move_verifica", ev(0,0,0,1,0,0,0,2'b00,4'd0,4'd0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
